snn_core_param: RTL

- Parametrised two-layer fully connected inference engine; successor to the fixed 784/32/10 core.
- Binary input image read one bit per cycle from the external input-unit memory. Hidden layer uses MAC, shift, saturate and activation-LUT lookup; output layer uses MAC and argmax.
- Weight ROM and activation LUT are external synchronous-read memories with 1-cycle latency. Hidden activations live in an internal register array.
- Sits between the image buffer / UART front end and the digit display / transmit logic.

---
 rtl/snn_core_param_if.sv | 46 ++++
 rtl/snn_core_param.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/snn_core_param_if.sv
// snn_core_param_if: bus between the inference core and its surroundings.
// Carries the start/busy/done/digit control handshake and the three external
// memory ports (input-unit bits, weight ROM, activation LUT).
// Optional bias words are enabled with the SNN_BIAS_EN macro; this changes the
// weight-address width, so the interface and the core must agree on it.
interface snn_core_param_if #(
  parameter int N_IN  = 784,
  parameter int N_HID = 32,
  parameter int N_OUT = 10,
  parameter int W_W   = 8,
  parameter int ACT_W = 8
);
`ifdef SNN_BIAS_EN
  localparam int HID_STRIDE = N_IN + 1;
  localparam int OUT_STRIDE = N_HID + 1;
`else
  localparam int HID_STRIDE = N_IN;
  localparam int OUT_STRIDE = N_HID;
`endif
  localparam int IN_AW   = $clog2(N_IN);
  localparam int WADDR_W = $clog2(N_HID * HID_STRIDE + N_OUT * OUT_STRIDE);
  localparam int OUT_W   = $clog2(N_OUT);

  logic               start;
  logic               q_input;
  logic [IN_AW-1:0]   addr_input_unit;
  logic [WADDR_W-1:0] w_addr;
  logic [W_W-1:0]     w_q;
  logic [ACT_W-1:0]   act_addr;
  logic [ACT_W-1:0]   act_q;
  logic               busy;
  logic [OUT_W-1:0]   digit;
  logic               done;

  // The core side: consumes start and memory read data, drives addresses and status.
  modport slave (
    input  start, q_input, w_q, act_q,
    output addr_input_unit, w_addr, act_addr, busy, digit, done
  );

  // The environment side: front end plus the external memories.
  modport master (
    output start, q_input, w_q, act_q,
    input  addr_input_unit, w_addr, act_addr, busy, digit, done
  );
endinterface

// File: rtl/snn_core_param.sv
// snn_core_param: parametrised two-layer fully connected inference engine.
// Hidden layer: binary-pixel MAC, arithmetic shift, saturation, activation LUT.
// Output layer: MAC against the stored hidden activations, then argmax.
// All weights come from one external ROM laid out neuron by neuron, so a single
// running pointer walks the whole ROM in order during an inference.
// Macro SNN_BIAS_EN appends one bias word per neuron and adds an extra MAC cycle.
module snn_core_param #(
  parameter int N_IN  = 784,
  parameter int N_HID = 32,
  parameter int N_OUT = 10,
  parameter int W_W   = 8,
  parameter int ACT_W = 8,
  parameter int ACC_W = 26,
  parameter int SHIFT = 4
) (
  input logic              clk,
  input logic              rst_n,
  snn_core_param_if.slave  bus
);
`ifdef SNN_BIAS_EN
  localparam int HID_STRIDE = N_IN + 1;
  localparam int OUT_STRIDE = N_HID + 1;
`else
  localparam int HID_STRIDE = N_IN;
  localparam int OUT_STRIDE = N_HID;
`endif
  localparam int IN_AW   = $clog2(N_IN);
  localparam int WADDR_W = $clog2(N_HID * HID_STRIDE + N_OUT * OUT_STRIDE);
  localparam int OUT_W   = $clog2(N_OUT);
  localparam int HID_AW  = (N_HID > 1) ? $clog2(N_HID) : 1;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (ACT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (ACT_W - 1)));

  typedef enum logic [3:0] {
    IDLE, HID_MAC, HID_BIAS, HID_DRAIN, HID_ACT, HID_WR,
    OUT_MAC, OUT_BIAS, OUT_DRAIN, OUT_CMP, DONE
  } state_e;

  // Kind of read issued last cycle; tells the accumulator how to use this cycle's data.
  typedef enum logic [1:0] {P_NONE, P_PIX, P_BIAS, P_OUT} prod_e;

  state_e state, state_n;
  prod_e  kind;

  logic [IN_AW-1:0]   i_cnt;
  logic [HID_AW-1:0]  h_cnt, j_cnt, j_d;
  logic [OUT_W-1:0]   o_cnt, best_idx, digit_r;
  logic [WADDR_W-1:0] ptr;
  logic [ACT_W-1:0]   act_addr_r, sat_val, hid_rd;
  logic [ACT_W-1:0]   hid [N_HID];

  logic signed [ACC_W-1:0] acc, acc_nx, best, prod, w_ext, hid_ext, shifted;
  logic last_i, last_j, last_h, last_o, take;

  assign last_i = (i_cnt == IN_AW'(N_IN - 1));
  assign last_j = (j_cnt == HID_AW'(N_HID - 1));
  assign last_h = (h_cnt == HID_AW'(N_HID - 1));
  assign last_o = (o_cnt == OUT_W'(N_OUT - 1));
  assign take   = (o_cnt == '0) || (acc > best);

  // State register; reset aborts any inference in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state sequencing through the hidden and output phases.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (bus.start) state_n = HID_MAC;
`ifdef SNN_BIAS_EN
      HID_MAC:   if (last_i) state_n = HID_BIAS;
`else
      HID_MAC:   if (last_i) state_n = HID_DRAIN;
`endif
      HID_BIAS:  state_n = HID_DRAIN;
      HID_DRAIN: state_n = HID_ACT;
      HID_ACT:   state_n = HID_WR;
      HID_WR:    state_n = last_h ? OUT_MAC : HID_MAC;
`ifdef SNN_BIAS_EN
      OUT_MAC:   if (last_j) state_n = OUT_BIAS;
`else
      OUT_MAC:   if (last_j) state_n = OUT_DRAIN;
`endif
      OUT_BIAS:  state_n = OUT_DRAIN;
      OUT_DRAIN: state_n = OUT_CMP;
      OUT_CMP:   state_n = last_o ? DONE : OUT_MAC;
      DONE:      state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  // Product of last cycle's reads, updated accumulator and its saturated LUT address.
  always_comb begin
    hid_rd  = hid[j_d];
    w_ext   = ACC_W'($signed(bus.w_q));
    hid_ext = ACC_W'(hid_rd);
    prod    = '0;
    case (kind)
      P_PIX:   prod = bus.q_input ? w_ext : '0;
      P_BIAS:  prod = w_ext;
      P_OUT:   prod = w_ext * hid_ext;
      default: prod = '0;
    endcase
    acc_nx  = acc + prod;
    shifted = acc_nx >>> SHIFT;
    if (shifted > SAT_MAX)      sat_val = {1'b0, {(ACT_W - 1){1'b1}}};
    else if (shifted < SAT_MIN) sat_val = {1'b1, {(ACT_W - 1){1'b0}}};
    else                        sat_val = shifted[ACT_W-1:0];
  end

  // Datapath: counters, weight pointer, accumulator, argmax tracking and result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kind       <= P_NONE;
      acc        <= '0;
      best       <= '0;
      best_idx   <= '0;
      digit_r    <= '0;
      i_cnt      <= '0;
      h_cnt      <= '0;
      j_cnt      <= '0;
      j_d        <= '0;
      o_cnt      <= '0;
      ptr        <= '0;
      act_addr_r <= '0;
    end else begin
      kind <= P_NONE;
      acc  <= acc_nx;
      case (state)
        IDLE: begin
          if (bus.start) begin
            acc   <= '0;
            i_cnt <= '0;
            h_cnt <= '0;
            j_cnt <= '0;
            o_cnt <= '0;
            ptr   <= '0;
          end
        end
        HID_MAC: begin
          i_cnt <= last_i ? '0 : i_cnt + 1'b1;
          ptr   <= ptr + 1'b1;
          kind  <= P_PIX;
        end
        HID_BIAS, OUT_BIAS: begin
          ptr  <= ptr + 1'b1;
          kind <= P_BIAS;
        end
        HID_DRAIN: begin
          act_addr_r <= {~sat_val[ACT_W-1], sat_val[ACT_W-2:0]};
        end
        HID_WR: begin
          acc <= '0;
          if (!last_h) h_cnt <= h_cnt + 1'b1;
        end
        OUT_MAC: begin
          j_d   <= j_cnt;
          j_cnt <= last_j ? '0 : j_cnt + 1'b1;
          ptr   <= ptr + 1'b1;
          kind  <= P_OUT;
        end
        OUT_CMP: begin
          acc <= '0;
          if (take) begin
            best     <= acc;
            best_idx <= o_cnt;
          end
          if (last_o) digit_r <= take ? o_cnt : best_idx;
          else        o_cnt   <= o_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Hidden activation store; contents are meaningless after reset so no reset here.
  always_ff @(posedge clk) begin
    if (state == HID_WR) hid[h_cnt] <= bus.act_q;
  end

  assign bus.addr_input_unit = i_cnt;
  assign bus.w_addr          = ptr;
  assign bus.act_addr        = act_addr_r;
  assign bus.busy            = (state != IDLE) && (state != DONE);
  assign bus.done            = (state == DONE);
  assign bus.digit           = digit_r;

endmodule
